// File: rtl/cursor_step_ctrl.sv
// ============================================================================
// Module      : cursor_step_ctrl
// Description : Turns held direction requests into rate-limited, edge-masked
//               single-cycle step pulses and an optional plot request.
//               Optional feature macro: MOVE_ACCEL_EN (accelerated cool-down).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cursor_step_ctrl #(
    parameter logic [9:0]  X_MAX       = 10'd159,
    parameter logic [9:0]  Y_MAX       = 10'd119,
    parameter logic [23:0] STEP_DIV    = 24'd833333,
    parameter logic [3:0]  ACCEL_AFTER = 4'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  dir_req,
    input  logic        paint_en,
    input  logic [9:0]  cur_x,
    input  logic [9:0]  cur_y,
    output logic [3:0]  dir_out,
    output logic        plot_valid,
    input  logic        plot_ready,
    output logic [9:0]  plot_x,
    output logic [9:0]  plot_y,
    output logic        busy
);

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_STEP   = 3'd1;
    localparam logic [2:0] C_ST_SETTLE = 3'd2;
    localparam logic [2:0] C_ST_PLOT   = 3'd3;
    localparam logic [2:0] C_ST_COOL   = 3'd4;

    logic [2:0]  state_q,     state_d;
    logic [3:0]  step_mask_q, step_mask_d;
    logic [3:0]  prev_mask_q, prev_mask_d;
    logic [3:0]  streak_q,    streak_d;
    logic [23:0] cnt_q,       cnt_d;
    logic [9:0]  plot_x_q,    plot_x_d;
    logic [9:0]  plot_y_q,    plot_y_d;

    logic [3:0]  w_mask_edge;
    logic [3:0]  w_mask;
    logic [23:0] w_cool_load;

    // Edge clamp first, then left/up take priority over right/down.
    always_comb begin
        w_mask_edge = dir_req;
        if (cur_x == 10'd0) w_mask_edge[3] = 1'b0;
        if (cur_x == X_MAX) w_mask_edge[1] = 1'b0;
        if (cur_y == 10'd0) w_mask_edge[2] = 1'b0;
        if (cur_y == Y_MAX) w_mask_edge[0] = 1'b0;
        w_mask = w_mask_edge;
        if (w_mask_edge[3]) w_mask[1] = 1'b0;
        if (w_mask_edge[2]) w_mask[0] = 1'b0;
    end

`ifdef MOVE_ACCEL_EN
    assign w_cool_load = (streak_q == ACCEL_AFTER) ? (STEP_DIV >> 2) : STEP_DIV;
`else
    assign w_cool_load = STEP_DIV;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= C_ST_IDLE;
            step_mask_q <= 4'd0;
            prev_mask_q <= 4'd0;
            streak_q    <= 4'd0;
            cnt_q       <= 24'd0;
            plot_x_q    <= 10'd0;
            plot_y_q    <= 10'd0;
        end else begin
            state_q     <= state_d;
            step_mask_q <= step_mask_d;
            prev_mask_q <= prev_mask_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            plot_x_q    <= plot_x_d;
            plot_y_q    <= plot_y_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:   if (w_mask != 4'd0) state_d = C_ST_STEP;
            C_ST_STEP:   state_d = C_ST_SETTLE;
            C_ST_SETTLE: state_d = paint_en ? C_ST_PLOT : C_ST_COOL;
            C_ST_PLOT:   if (plot_ready) state_d = C_ST_COOL;
            C_ST_COOL:   if (cnt_q <= 24'd1) state_d = C_ST_IDLE;
            default:     state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        step_mask_d = step_mask_q;
        prev_mask_d = prev_mask_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        plot_x_d    = plot_x_q;
        plot_y_d    = plot_y_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_mask != 4'd0)
                    step_mask_d = w_mask;
                else if (dir_req == 4'd0)
                    streak_d = 4'd0;
            end
            C_ST_STEP: begin
                if (step_mask_q == prev_mask_q)
                    streak_d = (streak_q >= ACCEL_AFTER) ? ACCEL_AFTER : streak_q + 4'd1;
                else
                    streak_d = 4'd1;
                prev_mask_d = step_mask_q;
            end
            C_ST_SETTLE: begin
                // Position registers took the step on the previous edge.
                plot_x_d = cur_x;
                plot_y_d = cur_y;
            end
            C_ST_COOL: begin
                cnt_d = cnt_q - 24'd1;
            end
            default: ;
        endcase

        if ((state_q != C_ST_COOL) && (state_d == C_ST_COOL))
            cnt_d = w_cool_load;
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        dir_out    = (state_q == C_ST_STEP) ? step_mask_q : 4'd0;
        plot_valid = (state_q == C_ST_PLOT);
        busy       = (state_q != C_ST_IDLE);
        plot_x     = plot_x_q;
        plot_y     = plot_y_q;
    end

endmodule

`default_nettype wire

// File: doc/cursor_step_ctrl.md
# cursor_step_ctrl

Sequencer for the paint cursor's movement datapath. It turns held direction requests into single-cycle step pulses at a controlled rate and masks any step that would leave the canvas. After each step it optionally issues a valid/ready plot request carrying the updated cursor coordinates. It sits between input decode and the cursor position registers / VGA plot writer.

## Interface
- X_MAX, 159: largest legal cursor x (10-bit).
- Y_MAX, 119: largest legal cursor y (10-bit).
- STEP_DIV, 833333: cool-down cycles between steps (24-bit, must be ≥4).
- ACCEL_AFTER, 8: same-direction step count before acceleration (4-bit, ≥1).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- dir_req  in  4  requested directions: [3] left, [2] up, [1] right, [0] down.
- paint_en  in  1  plot after each step when high.
- cur_x  in  10  current cursor x from the position registers.
- cur_y  in  10  current cursor y from the position registers.
- dir_out  out  4  step command to the position registers; same bit order as dir_req.
- plot_valid  out  1  plot request valid.
- plot_ready  in  1  plot writer accepts the request.
- plot_x  out  10  plot x coordinate.
- plot_y  out  10  plot y coordinate.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- The mask is computed from dir_req:
  - Clear left if cur_x==0 and right if cur_x==X_MAX.
  - Clear up if cur_y==0 and down if cur_y==Y_MAX.
  - Then clear right if left is set, and down if up is set. Left and up win, matching the datapath's priority.
- State machine: IDLE, STEP, SETTLE, PLOT, COOL.
- IDLE:
  - If mask≠0, latch it into step_mask and go to STEP.
  - Otherwise stay in IDLE. If dir_req==0, clear streak.
- STEP:
  - dir_out=step_mask for exactly this one cycle. It is 0 in every other state.
  - Update streak: if step_mask==prev_mask, streak=min(streak+1, ACCEL_AFTER); otherwise streak=1.
  - Set prev_mask=step_mask, then go to SETTLE.
- SETTLE: one wait cycle while the datapath registers update.
  - Register plot_x=cur_x and plot_y=cur_y on exit.
  - Go to PLOT if paint_en, else COOL.
- PLOT:
  - plot_valid=1; plot_x and plot_y are held stable.
  - Transfer happens on an edge where plot_valid and plot_ready are both high. After the transfer go to COOL.
  - dir_req is ignored while in PLOT.
- COOL:
  - Load a counter on entry:
    - D = STEP_DIV normally.
    - D = STEP_DIV>>2 when MOVE_ACCEL_EN is defined and streak==ACCEL_AFTER.
  - Stay in COOL exactly D cycles, then go to IDLE.
- All outputs come from registers or state decode. There is no combinational path from any input to any output.

## Timing
- Reset state:
  - State IDLE; dir_out=0, plot_valid=0, plot_x=0, plot_y=0, busy=0.
  - Counter=0, streak=0, prev_mask=0, step_mask=0.
- Step sequence, with mask nonzero sampled at edge n:
  - dir_out is high during cycle n→n+1.
  - The datapath updates at edge n+1.
  - plot_x/plot_y hold the new position from edge n+2, with plot_valid high from edge n+2.
- Step period with dir_req held constant:
  - Without painting: D+3 cycles.
  - With painting and plot_ready held high: D+4 cycles.
  - Plot backpressure stretches the period by one cycle per stalled cycle.
- Reset mid-operation: reset has priority in every state. It returns to IDLE next edge and drops plot_valid without a transfer.
- A fully masked request (e.g. left+up at 0,0) never leaves IDLE. busy stays 0.
- A paint_en change during COOL has no effect until the next step.

## Configuration
- MOVE_ACCEL_EN defined: after ACCEL_AFTER consecutive steps with identical step_mask, each subsequent cool-down is STEP_DIV>>2. Any direction change, or dir_req==0 in IDLE, resets the streak.
- MOVE_ACCEL_EN undefined: streak logic is still present, but every cool-down is STEP_DIV.

## Test plan
- Reset: assert reset 3 cycles with arbitrary inputs. Require all outputs 0 and busy=0 next cycle.
- Single step: cur=(10,20), dir_req=0010, paint_en=1, plot_ready=1, datapath model attached. Require dir_out=0010 for one cycle, plot_valid for one cycle, plot=(11,20).
- Clamp:
  - cur=(0,5), dir_req=1100: dir_out=0100, next plot=(0,4).
  - cur=(0,0), dir_req=1100: dir_out stays 0, busy stays 0.
- Backpressure: plot_ready low for 10 cycles in PLOT. plot_valid stays high, plot_x/y stay stable, dir_out=0, transfer on the first ready edge.
- Rate and acceleration: STEP_DIV=16, ACCEL_AFTER=8, hold dir_req=0010, paint_en=0, MOVE_ACCEL_EN defined.
  - dir_out pulses every 19 cycles.
  - The gap after the 8th pulse and all later gaps are 7 cycles.
  - Switching to 0001 restores 19-cycle gaps. Without the macro, all gaps are 19.
- Reset mid-PLOT with plot_ready low: plot_valid=0 next cycle, state IDLE, no transfer recorded.
